// File: rtl/lib_cpu_pkg.sv
// Shared CPU pipeline types.
//   SPECIAL_REG  - architectural special registers committed by mem/wb
//   EXECUTE      - execute-stage result consumed by cpu_mem_wb
//   WB           - register-file write port bundle
//   MEMWB_STATE  - mem/wb control FSM states
package lib_cpu;

  localparam int XLEN     = 32;
  localparam int RF_NREG  = 16;
  localparam int RF_IDX_W = $clog2(RF_NREG);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      flags;
    logic            ie;
  } SPECIAL_REG;

  typedef struct packed {
    logic            w_rd;       // result targets the register file
    logic [XLEN-1:0] x_rd;       // ALU result, or store data for stores
    logic            mem_r_req;
    logic            mem_w_req;
    logic [XLEN-1:0] mem_addr;   // word address
    SPECIAL_REG      sr;
  } EXECUTE;

  typedef struct packed {
    logic                we;
    logic [RF_IDX_W-1:0] waddr;
    logic [XLEN-1:0]     wdata;
  } WB;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } MEMWB_STATE;

endpackage

// File: rtl/cpu_mem_wb_dmem.sv
// Data memory: one write port shared by the pipeline store and the boot/debug
// load port, plus a registered read port.
//   clk                       - clock
//   st_we/st_addr/st_data     - pipeline store (wins over the load port)
//   ld_we/ld_addr/ld_data     - boot/debug write
//   rd_en/rd_addr, rd_data    - read, data valid the cycle after rd_en
//   collision                 - store and load-port write in the same cycle
module cpu_dmem #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          st_we,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic          collision
);

  logic [31:0]   mem_reg [DEPTH];
  logic [31:0]   rd_data_reg;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  // Store has priority; a simultaneous load-port write is dropped.
  always_comb begin
    wr_en   = st_we | ld_we;
    wr_addr = st_we ? st_addr : ld_addr;
    wr_data = st_we ? st_data : ld_data;
  end

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data   = rd_data_reg;
  assign collision = st_we & ld_we;

endmodule

// File: rtl/cpu_mem_wb.sv
// Memory / write-back stage.
//   clk, rst_n            - clock, asynchronous active-low reset
//   ex_valid, ex_ready    - handshake with execute (ready drops for one cycle per load)
//   ex, ex_rd_idx         - execute result and destination register
//   ld_we/ld_addr/ld_data - boot/debug data-memory write
//   rf_we/rf_waddr/rf_wdata - register-file write port (single-cycle pulse)
//   sr_out                - committed special registers
//   err                   - sticky protocol error (r+w request, or ld/store collision)
module cpu_mem_wb
  import lib_cpu::*;
#(
  parameter  int DEPTH = 64,
  parameter  int NREG  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int RW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  EXECUTE        ex,
  input  logic [RW-1:0] ex_rd_idx,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [31:0]   rf_wdata,
  output SPECIAL_REG    sr_out,
  output logic          err
);

  MEMWB_STATE    state_reg, state_next;
  WB             wb_reg, wb_next;
  logic          pend_we_reg, pend_we_next;
  logic [RW-1:0] pend_idx_reg, pend_idx_next;
  SPECIAL_REG    sr_reg;
  logic          err_reg, err_next;

  logic          fire;
  logic          is_load;
  logic          is_alu;
  logic          rd_writes;
  logic          st_we;
  logic          collision;
  logic [31:0]   rd_data;
  logic [AW-1:0] mem_addr_w;
  logic          unused_addr_bits;

  assign ex_ready   = (state_reg == IDLE);
  assign fire       = ex_valid & ex_ready;
  assign is_load    = ex.mem_r_req & ~ex.mem_w_req;
  assign is_alu     = ~ex.mem_r_req & ~ex.mem_w_req;
  assign rd_writes  = ex.w_rd & (ex_rd_idx != '0);
  // A request with both r and w set is executed as a store.
  assign st_we      = fire & ex.mem_w_req;
  assign mem_addr_w = ex.mem_addr[AW-1:0];
  assign unused_addr_bits = ^ex.mem_addr[31:AW];

  cpu_dmem #(.DEPTH(DEPTH)) u_dmem (
    .clk       (clk),
    .st_we     (st_we),
    .st_addr   (mem_addr_w),
    .st_data   (ex.x_rd),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rd_en     (fire & is_load),
    .rd_addr   (mem_addr_w),
    .rd_data   (rd_data),
    .collision (collision)
  );

  always_comb begin
    state_next    = state_reg;
    wb_next       = wb_reg;
    wb_next.we    = 1'b0;             // waddr/wdata hold, we is a pulse
    pend_we_next  = pend_we_reg;
    pend_idx_next = pend_idx_reg;
    err_next      = err_reg | collision | (fire & ex.mem_r_req & ex.mem_w_req);
    case (state_reg)
      IDLE: begin
        if (fire) begin
          if (is_load) begin
            state_next    = LOAD;
            pend_we_next  = rd_writes;
            pend_idx_next = ex_rd_idx;
          end else if (is_alu && rd_writes) begin
            wb_next.we    = 1'b1;
            wb_next.waddr = RF_IDX_W'(ex_rd_idx);
            wb_next.wdata = ex.x_rd;
          end
        end
      end
      LOAD: begin
        // RAM data read in the accept cycle is valid now.
        state_next = IDLE;
        if (pend_we_reg) begin
          wb_next.we    = 1'b1;
          wb_next.waddr = RF_IDX_W'(pend_idx_reg);
          wb_next.wdata = rd_data;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wb_reg       <= '0;
      pend_we_reg  <= 1'b0;
      pend_idx_reg <= '0;
      sr_reg       <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wb_reg       <= wb_next;
      pend_we_reg  <= pend_we_next;
      pend_idx_reg <= pend_idx_next;
      err_reg      <= err_next;
      if (fire) begin
        sr_reg <= ex.sr;
      end
    end
  end

  assign rf_we    = wb_reg.we;
  assign rf_waddr = RW'(wb_reg.waddr);
  assign rf_wdata = wb_reg.wdata;
  assign sr_out   = sr_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_cpu_mem_wb.sv
module tb_cpu_mem_wb;
  import lib_cpu::*;

  localparam int DEPTH = 64;
  localparam int NREG  = 16;
  localparam int AW    = 6;
  localparam int RW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_ready;
  EXECUTE        ex;
  logic [RW-1:0] ex_rd_idx;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  SPECIAL_REG    sr_out;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_mem_wb #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex(ex), .ex_rd_idx(ex_rd_idx), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sr_out(sr_out), .err(err)
  );

  // Reference model: memory array, expected outputs, one pending load.
  logic [31:0]   mem_m [DEPTH];
  logic          e_we, e_err, e_ready;
  logic [RW-1:0] e_waddr;
  logic [31:0]   e_wdata;
  SPECIAL_REG    e_sr;
  logic          p_we;
  logic [RW-1:0] p_idx;
  logic [31:0]   p_data;

  function automatic void m_reset();
    e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_sr = '0; e_err = 1'b0; e_ready = 1'b1;
    p_we = 1'b0;
  endfunction

  function automatic void m_step();
    logic [AW-1:0] a;
    logic fire, st;
    a    = ex.mem_addr[AW-1:0];
    fire = ex_valid && e_ready;
    st   = fire && ex.mem_w_req;
    if (!e_ready) begin
      e_we = p_we;
      if (p_we) begin e_waddr = p_idx; e_wdata = p_data; end
      e_ready = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    if (fire) begin
      e_sr = ex.sr;
      if (ex.mem_w_req) begin
        if (ex.mem_r_req) e_err = 1'b1;
      end else if (ex.mem_r_req) begin
        e_ready = 1'b0;
        p_we    = ex.w_rd && (ex_rd_idx != 0);
        p_idx   = ex_rd_idx;
        p_data  = mem_m[a];
      end else if (ex.w_rd && ex_rd_idx != 0) begin
        e_we = 1'b1; e_waddr = ex_rd_idx; e_wdata = ex.x_rd;
      end
    end
    if (st) mem_m[a] = ex.x_rd;
    if (ld_we) begin
      if (st) e_err = 1'b1;
      else    mem_m[ld_addr] = ld_data;
    end
  endfunction

  function automatic logic [75:0] obs();
    return {rf_we, rf_waddr, rf_wdata, sr_out, err, ex_ready};
  endfunction

  function automatic logic [75:0] expv();
    return {e_we, e_waddr, e_wdata, e_sr, e_err, e_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_step();
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ld_we = 1'b0;
  endtask

  task automatic set_ex(input logic w_rd, input logic [31:0] x, input logic r, input logic w,
                        input logic [31:0] addr, input logic [RW-1:0] idx, input logic [31:0] pc);
    ex_valid     = 1'b1;
    ex.w_rd      = w_rd;
    ex.x_rd      = x;
    ex.mem_r_req = r;
    ex.mem_w_req = w;
    ex.mem_addr  = addr;
    ex.sr.pc     = pc;
    ex.sr.flags  = 4'($urandom);
    ex.sr.ie     = 1'($urandom);
    ex_rd_idx    = idx;
    ld_we        = 1'b0;
  endtask

  task automatic junk();
    set_ex(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle_in(); ex = '0; ex_rd_idx = '0; ld_addr = '0; ld_data = '0;
    #1 rst_n = 1'b0; m_reset();
    #1;
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL reset_async got %h exp %h", obs(), expv());
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL reset_release got %h exp %h", obs(), expv());
    end
    $display("reset: outputs=%h", obs());
  endtask

  task automatic test_alu();
    set_ex(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'd5, 32'h40);
    tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, sr_out.pc, ex_ready} !== {1'b1, 4'd5, 32'hDEADBEEF, 32'h40, 1'b1}) begin
      n_bad++; $display("FAIL alu_fixed got we=%b wa=%0d wd=%h pc=%h exp we=1 wa=5 wd=deadbeef pc=40",
                        rf_we, rf_waddr, rf_wdata, sr_out.pc);
    end
    for (int i = 0; i < 24; i++) begin
      set_ex(1'($urandom), $urandom, 1'b0, 1'b0, $urandom, 4'($urandom), $urandom);
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL alu_b2b[%0d] got %h exp %h", i, obs(), expv());
      end
      $display("alu %0d: rf_we=%b waddr=%0d wdata=%h", i, rf_we, rf_waddr, rf_wdata);
    end
    idle_in();
    tick();
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL alu_idle_hold got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      idle_in();
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = $urandom;
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL fill[%0d] got %h exp %h", i, obs(), expv());
      end
    end
    idle_in();
    $display("fill: %0d words via ld port", DEPTH);
  endtask

  task automatic test_store_load();
    set_ex(1'b1, 32'h12345678, 1'b0, 1'b1, {26'($urandom), 6'd7}, 4'd2, 32'h100);
    tick();
    set_ex(1'b1, $urandom, 1'b1, 1'b0, 32'd7, 4'd3, 32'h104);
    tick();
    n_cmp++;
    if ({ex_ready, rf_we} !== 2'b00) begin
      n_bad++; $display("FAIL load_stall got ready=%b we=%b exp ready=0 we=0", ex_ready, rf_we);
    end
    junk();
    tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, ex_ready} !== {1'b1, 4'd3, 32'h12345678, 1'b1}) begin
      n_bad++; $display("FAIL load_data got we=%b wa=%0d wd=%h exp we=1 wa=3 wd=12345678",
                        rf_we, rf_waddr, rf_wdata);
    end
    // Addresses 63 and 0 are distinct words; upper address bits are ignored.
    set_ex(1'b0, 32'hAAAA0063, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'd1, 32'h108); tick();
    set_ex(1'b0, 32'hBBBB0000, 1'b0, 1'b1, 32'h0000_0040, 4'd1, 32'h10C); tick();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd63, 4'd8, 32'h110); tick(); junk(); tick();
    n_cmp++;
    if (rf_wdata !== 32'hAAAA0063) begin
      n_bad++; $display("FAIL addr63 got %h exp aaaa0063", rf_wdata);
    end
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd0, 4'd9, 32'h114); tick(); junk(); tick();
    n_cmp++;
    if (rf_wdata !== 32'hBBBB0000) begin
      n_bad++; $display("FAIL addr0 got %h exp bbbb0000", rf_wdata);
    end
    for (int i = 0; i < 60; i++) begin
      if (e_ready) begin
        int kind;
        logic [31:0] a;
        kind = $urandom_range(0, 2);
        a = $urandom;
        set_ex(1'($urandom), $urandom, kind == 2, kind == 1, a, 4'($urandom), $urandom);
        if (kind != 1 && ($urandom % 3) == 0) begin
          ld_we = 1'b1; ld_addr = a[AW-1:0] + 6'd1; ld_data = $urandom;
        end
      end else begin
        junk();
      end
      tick();
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++; $display("FAIL mix[%0d] got %h exp %h", i, obs(), expv());
      end
      $display("mix %0d: ready=%b rf_we=%b waddr=%0d wdata=%h", i, ex_ready, rf_we, rf_waddr, rf_wdata);
    end
    idle_in();
    tick();
  endtask

  task automatic test_zero_idx();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd5, 4'd0, 32'h200);
    tick(); junk(); tick();
    n_cmp++;
    if ({rf_we, sr_out.pc} !== {1'b0, 32'h200}) begin
      n_bad++; $display("FAIL load_idx0 got we=%b pc=%h exp we=0 pc=200", rf_we, sr_out.pc);
    end
    set_ex(1'b0, 32'hCAFE, 1'b0, 1'b0, 32'd0, 4'd9, 32'h204);
    tick();
    n_cmp++;
    if ({rf_we, sr_out.pc} !== {1'b0, 32'h204}) begin
      n_bad++; $display("FAIL alu_nowrd got we=%b pc=%h exp we=0 pc=204", rf_we, sr_out.pc);
    end
    idle_in();
    $display("zero_idx: rf_we=%b pc=%h", rf_we, sr_out.pc);
  endtask

  task automatic test_collisions();
    set_ex(1'b1, 32'hA5, 1'b1, 1'b1, 32'd2, 4'd4, 32'h300);
    tick();
    n_cmp++;
    if ({err, rf_we, ex_ready} !== 3'b101) begin
      n_bad++; $display("FAIL rw_both got err=%b we=%b ready=%b exp err=1 we=0 ready=1", err, rf_we, ex_ready);
    end
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd2, 4'd1, 32'h304); tick(); junk(); tick();
    n_cmp++;
    if (rf_wdata !== 32'hA5) begin
      n_bad++; $display("FAIL rw_both_mem got %h exp a5", rf_wdata);
    end
    set_ex(1'b0, 32'h2222, 1'b0, 1'b1, 32'd9, 4'd1, 32'h308);
    ld_we = 1'b1; ld_addr = 6'd9; ld_data = 32'h1111;
    tick();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd9, 4'd2, 32'h30C); tick(); junk(); tick();
    n_cmp++;
    if ({rf_wdata, err} !== {32'h2222, 1'b1}) begin
      n_bad++; $display("FAIL ld_collide got wd=%h err=%b exp wd=2222 err=1", rf_wdata, err);
    end
    idle_in();
    tick(); tick();
    n_cmp++;
    if (obs() !== expv()) begin
      n_bad++; $display("FAIL err_sticky got %h exp %h", obs(), expv());
    end
    $display("collisions: err=%b", err);
  endtask

  task automatic test_reset_load();
    set_ex(1'b1, 32'h0, 1'b1, 1'b0, 32'd7, 4'd4, 32'h400);
    tick();
    junk();
    rst_n = 1'b0; m_reset();
    #1;
    n_cmp++;
    if ({rf_we, sr_out, err, ex_ready} !== {1'b0, 37'h0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_in_load got %h exp reset values", obs());
    end
    tick();
    rst_n = 1'b1;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rf_we !== 1'b0) begin
        n_bad++; $display("FAIL reset_discard[%0d] got rf_we=%b exp 0", i, rf_we);
      end
    end
    set_ex(1'b1, 32'h600DF00D, 1'b0, 1'b0, 32'd0, 4'd6, 32'h404);
    tick();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'd6, 32'h600DF00D}) begin
      n_bad++; $display("FAIL after_reset got we=%b wa=%0d wd=%h exp we=1 wa=6 wd=600df00d",
                        rf_we, rf_waddr, rf_wdata);
    end
    idle_in();
    $display("reset_load: post-reset write wdata=%h", rf_wdata);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_fill();
    test_store_load();
    test_zero_idx();
    test_collisions();
    test_reset_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_wb.md
Name: cpu_mem_wb

Overview:
- Memory/write-back stage; sits directly downstream of the execute stage and consumes the lib_cpu::EXECUTE result.
- Performs the data-memory access (internal 32-bit word RAM) and produces the register-file write port.
- Commits the special-register bundle (SPECIAL_REG) to the architectural copy used by fetch/interrupt logic.
- Exposes a valid/ready handshake so loads can stall execute for one cycle.

Parameters:
- DEPTH, 64, data-memory words; address width AW = $clog2(DEPTH); mem_addr bits above AW-1 ignored.
- NREG, 16, register-file entries; index width $clog2(NREG); index 0 is hard-wired zero.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute result present this cycle
- ex_ready  out  1  stage accepts ex this cycle
- ex  in  lib_cpu::EXECUTE  execute result (w_rd, x_rd, mem_r_req, mem_w_req, mem_addr, sr)
- ex_rd_idx  in  $clog2(NREG)  destination register index
- ld_we  in  1  boot/debug memory load strobe
- ld_addr  in  AW  boot load address
- ld_data  in  32  boot load data
- rf_we  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  $clog2(NREG)  register-file write index
- rf_wdata  out  32  register-file write data
- sr_out  out  lib_cpu::SPECIAL_REG  committed special registers
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, sr_out=all zero, err=0, FSM=IDLE (so ex_ready=1). RAM contents are not reset.
- Accept: fire = ex_valid & ex_ready. ex_ready = (state==IDLE), combinational from state only.
- FSM states: IDLE, LOAD.
  - IDLE + fire + mem_r_req & !mem_w_req -> LOAD. The RAM read is issued in the accept cycle; latch rd index and w_rd.
  - LOAD -> IDLE unconditionally after 1 cycle.
- Non-load accepted in cycle T:
  - sr_out <= ex.sr at the edge ending T.
  - rf_we=1 in T+1 iff ex.w_rd & ex_rd_idx!=0; then rf_wdata=ex.x_rd and rf_waddr=ex_rd_idx.
  - Throughput: 1 per cycle.
- Store (mem_w_req & !mem_r_req): RAM[mem_addr[AW-1:0]] <= ex.x_rd at the accept edge. Store data is carried in x_rd. No rf write regardless of w_rd.
- Load accepted in T:
  - sr_out updated at the end of T.
  - In T+1 the state is LOAD, ex_ready=0 and rf_we=0.
  - In T+2, rf_we=1 (if w_rd & idx!=0) with rf_wdata = RAM word read at T.
  - A store in the same accept cycle as a read is impossible, because the read only happens on accept.
- rf_we is a single-cycle pulse, deasserted otherwise; rf_waddr/rf_wdata hold their last values when rf_we=0.
- Both mem_r_req & mem_w_req set: perform the store only, no rf write, no LOAD state, err<=1.
- ld_we:
  - Writes RAM[ld_addr] <= ld_data when no store is accepted in the same cycle.
  - If a pipeline store fires in the same cycle, the store wins, ld is dropped, and err<=1.
- err is sticky until reset.
- Reset mid-LOAD: FSM returns to IDLE immediately and the pending write-back is discarded (no rf_we after release).
- Address wrap: mem_addr is truncated to AW bits; with DEPTH=64, address 63 and address 0 are distinct, and there is no wrap beyond the field.
- ex is sampled only on fire; the ex contents while ex_ready=0 are don't-care.

Decomposition:
- lib_cpu gains:
  - WB typedef struct packed {we, waddr, wdata}.
  - The FSM enum MEMWB_STATE {IDLE, LOAD}.
- One sub-module, cpu_dmem: single-port-write/registered-read RAM with a write-priority mux between the pipeline store and ld port. It exposes a collision output used to set err.
- The FSM, sr commit and rf port stay in cpu_mem_wb.

Test Plan:
- Reset: assert rst_n=0 mid-run -> rf_we=0, sr_out=0, err=0, ex_ready=1 asynchronously, before the next clock edge.
- ALU write-back: ex_valid with w_rd=1, idx=5, x_rd=0xDEADBEEF, sr.pc=0x40 -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; sr_out.pc=0x40; back-to-back each cycle is accepted.
- Store then load: store addr=7 data=0x12345678, then load addr=7 idx=3 -> ex_ready=0 one cycle; rf_we with wdata=0x12345678 two cycles after load accept.
- idx=0 / w_rd=0: load to idx 0 and ALU op with w_rd=0 -> no rf_we pulse; sr_out still updates.
- Collisions:
  - mem_r_req=mem_w_req=1 addr=2 data=0xA5 -> RAM[2]=0xA5, no rf_we, err=1 sticky.
  - ld_we with a simultaneous store to the same address -> the store value remains, err=1.
- Reset during LOAD: rst_n low in the LOAD cycle -> no rf_we after release; the next accepted op proceeds normally.
